// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480 timing defaults, colour width, the layout
// of the two packed FIFO words and the test-pattern rectangle.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned COLOR_W = 10;
  localparam int unsigned WORD_W  = 16;

  // word 1 = {unused, g[9:5], r[9:0]}, word 2 = {unused, g[4:0], b[9:0]}
  localparam int unsigned R_LSB    = 0;
  localparam int unsigned B_LSB    = 0;
  localparam int unsigned G_HI_LSB = 10;
  localparam int unsigned G_LO_LSB = 10;
  localparam int unsigned FIELD_W  = 5;

  localparam int unsigned TP_X_LO = 100;
  localparam int unsigned TP_X_HI = 130;
  localparam int unsigned TP_Y_LO = 100;
  localparam int unsigned TP_Y_HI = 200;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // Per-pixel attributes carried alongside the read data
  typedef struct packed {
    logic             act;
    logic             hs;
    logic             vs;
    logic             fs;
    logic             req;
    logic             bad;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } pix_meta_t;

  // Bit 15 of each word carries nothing, so only the low 15 bits are taken.
  function automatic rgb_t unpack_words(input logic [WORD_W-2:0] w1,
                                        input logic [WORD_W-2:0] w2);
    rgb_t c;
    c.r = w1[R_LSB +: COLOR_W];
    c.g = {w1[G_HI_LSB +: FIELD_W], w2[G_LO_LSB +: FIELD_W]};
    c.b = w2[B_LSB +: COLOR_W];
    return c;
  endfunction

endpackage

// File: rtl/vga_frame_reader_timing.sv
// vga_timing_gen: horizontal/vertical counters and the stage-0 decode of
// active region, syncs, frame origin and start of vertical blank.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             vga_clk,
  input  logic             reset,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hs,
  output logic             vs,
  output logic             frame_origin,
  output logic             vblank_start
);

  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Raster scan: h wraps every line, v advances on each h wrap
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage-0 decode of the current counter position
  always_comb begin
    active       = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs           = (h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI);
    vs           = (v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI);
    frame_origin = (h_cnt == '0) && (v_cnt == '0);
    vblank_start = (h_cnt == '0) && (v_cnt == V_ACT_C);
  end

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: reads the SDRAM framebuffer FIFOs in step with VGA
// timing, unpacks the two words into 10-bit RGB and outputs colour, syncs,
// blank and coordinates all describing the same pixel.
// Optional: define VGA_FRAME_READER_TESTPATTERN_EN to add the test_mode
// input that overrides the colour with a fixed rectangle pattern.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [15:0] rd_word_1,
  input  logic [15:0] rd_word_2,
  input  logic        rd1_empty,
  input  logic        rd2_empty,
`ifdef VGA_FRAME_READER_TESTPATTERN_EN
  input  logic        test_mode,
`endif
  output logic        rd_req,
  output logic        rd_load,
  output logic [9:0]  vga_r,
  output logic [9:0]  vga_g,
  output logic [9:0]  vga_b,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        blank_n,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic        underflow
);

  // Attribute stages before the output register; the output register
  // itself is the last of the PIPE = RD_LATENCY + 2 stages.
  localparam int unsigned PIPE   = RD_LATENCY + 2;
  localparam int unsigned META_D = PIPE - 1;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active0;
  logic             hs0;
  logic             vs0;
  logic             fs0;
  logic             vblank_start0;
  logic             armed;
  logic             fifo_empty;
  pix_meta_t        meta [META_D];
  pix_meta_t        m_out;
  rgb_t             fifo_rgb;
  rgb_t             pix_rgb;
  logic             unused_word_msbs;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .active       (active0),
    .hs           (hs0),
    .vs           (vs0),
    .frame_origin (fs0),
    .vblank_start (vblank_start0)
  );

  assign unused_word_msbs = rd_word_1[15] ^ rd_word_2[15];
  assign fifo_empty       = rd1_empty || rd2_empty;
  assign rd_req           = meta[0].req;
  assign m_out            = meta[META_D-1];

  // FIFO rewind once per frame at vertical-blank entry; reads are enabled
  // from the first rewind after reset onward
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rd_load <= 1'b0;
      armed   <= 1'b0;
    end else begin
      rd_load <= vblank_start0;
      if (vblank_start0) armed <= 1'b1;
    end
  end

  // Attribute pipeline; stage 0 is the read strobe itself, and the empty
  // flags seen during that strobe tag the pixel on entry to stage 1
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < META_D; i++) meta[i] <= '0;
    end else begin
      meta[0] <= '{act: active0, hs: hs0, vs: vs0, fs: fs0,
                   req: active0 && armed, bad: 1'b0, x: h_cnt, y: v_cnt};
      meta[1]     <= meta[0];
      meta[1].bad <= meta[0].req && fifo_empty;
      for (int unsigned i = 2; i < META_D; i++) meta[i] <= meta[i-1];
    end
  end

  // Sticky underflow: any read strobe issued while either FIFO is empty
  always_ff @(posedge vga_clk) begin
    if (reset) underflow <= 1'b0;
    else if (meta[0].req && fifo_empty) underflow <= 1'b1;
  end

`ifdef VGA_FRAME_READER_TESTPATTERN_EN
  logic in_rect;
  assign in_rect = (m_out.x >= CNT_W'(TP_X_LO)) && (m_out.x < CNT_W'(TP_X_HI)) &&
                   (m_out.y >= CNT_W'(TP_Y_LO)) && (m_out.y < CNT_W'(TP_Y_HI));
`endif

  // Colour select: FIFO data only for a requested, non-underflowed visible pixel
  always_comb begin
    fifo_rgb = unpack_words(rd_word_1[14:0], rd_word_2[14:0]);
    pix_rgb  = '0;
    if (m_out.act && m_out.req && !m_out.bad) pix_rgb = fifo_rgb;
`ifdef VGA_FRAME_READER_TESTPATTERN_EN
    if (test_mode && m_out.act) begin
      if (in_rect) pix_rgb = '{r: 10'h3FF, g: 10'h01F, b: 10'h000};
      else         pix_rgb = '{r: 10'h000, g: 10'h01F, b: 10'h3FF};
    end
`endif
  end

  // Output register: final pipe stage, data word sampled RD_LATENCY after rd_req
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      blank_n     <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= pix_rgb.r;
      vga_g       <= pix_rgb.g;
      vga_b       <= pix_rgb.b;
      hsync_n     <= ~m_out.hs;
      vsync_n     <= ~m_out.vs;
      blank_n     <= m_out.act;
      pixel_x     <= m_out.x;
      pixel_y     <= m_out.y;
      frame_start <= m_out.fs;
    end
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- VGA-side consumer of the framebuffer written by the sys_clk pixel engine into SDRAM.
- Generates 640x480 VGA timing on vga_clk and issues read requests to the two SDRAM read FIFOs (RD1 and RD2 of Sdram_Control_4Port).
- Unpacks the two 16-bit words into 10-bit R/G/B and drives sync/blank aligned to the pixel data.
- Pulses the FIFO reload strobe once per frame so read pointers rewind to address 0 every frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- RD_LATENCY, 1, vga_clk cycles from rd_req to valid rd_word_1/2

Ports:
- vga_clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- rd_word_1  in  16  RD1 FIFO data: {unused, g[9:5], r[9:0]}
- rd_word_2  in  16  RD2 FIFO data: {unused, g[4:0], b[9:0]}
- rd1_empty  in  1  RD1 FIFO empty
- rd2_empty  in  1  RD2 FIFO empty
- rd_req  out  1  read strobe to both FIFOs (RD1 and RD2 tied together)
- rd_load  out  1  one-cycle FIFO reload pulse (RD1_LOAD/RD2_LOAD)
- vga_r, vga_g, vga_b  out  10 each  pixel colour
- hsync_n, vsync_n  out  1  active-low syncs
- blank_n  out  1  high during the active region
- pixel_x, pixel_y  out  10 each  coordinates of the pixel currently on vga_r/g/b
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0) on outputs
- underflow  out  1  sticky FIFO underflow flag

Behaviour:
- Reset is synchronous, active-high, on vga_clk. Reset values:
  - All outputs 0, except hsync_n=1, vsync_n=1.
  - h_cnt=0, v_cnt=0, armed=0, all pipeline stages cleared.
  - Reset mid-frame aborts the frame immediately. No rd_load is issued until the next vertical-blank entry.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H_* parameters (800).
  - v_cnt advances when h_cnt wraps and runs 0..V_TOTAL-1 (V_TOTAL = 525), then wraps to 0.
- Stage-0 decode:
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs is the same form on v_cnt.
- rd_load:
  - Registered pulse, asserted the cycle after h_cnt==0 && v_cnt==V_ACTIVE (start of vertical blank).
  - Exactly one pulse per frame.
  - Sets armed=1; armed stays 1 until reset.
- rd_req:
  - Registered: rd_req <= active && armed.
  - No reads are issued in the first partial frame after reset.
  - Exactly H_ACTIVE*V_ACTIVE = 307200 requests per armed frame.
- Data capture:
  - Word data is sampled RD_LATENCY cycles after rd_req.
  - r = w1[9:0]; g = {w1[14:10], w2[14:10]}; b = w2[9:0]; bit 15 of both words ignored.
- Pipeline depth PIPE = RD_LATENCY+2.
  - active, hs, vs, h_cnt, v_cnt and the frame-start condition are delayed PIPE cycles.
  - All outputs therefore describe the same pixel.
  - Colour outputs are forced 0 when the delayed blank_n=0.
- Unarmed frames: delayed active may be 1 while rd_req was 0. Colour outputs are then 0; blank_n still follows timing.
- Underflow:
  - If rd_req=1 in a cycle where rd1_empty or rd2_empty is 1, underflow is set (sticky until reset).
  - The affected pixel, tagged through the pipe, is output black.
- frame_start: delayed (h_cnt==0 && v_cnt==0) condition, asserted regardless of armed.

Optional Feature:
- Macro: VGA_FRAME_READER_TESTPATTERN_EN.
- Defined:
  - Adds input test_mode (1 bit).
  - When test_mode=1, output colour is replaced with the pattern:
    - x in [100,130) and y in [100,200): r=3FF, g=01F, b=000.
    - Otherwise: r=000, g=01F, b=3FF.
  - rd_req and rd_load are unchanged, so FIFOs keep draining.
  - Blanking still forces 0.
- Undefined: test_mode port absent; colour comes only from the FIFO words.

Decomposition:
- Package vga_pkg holds:
  - timing constants (H_/V_ defaults, H_TOTAL, V_TOTAL);
  - the colour width (10);
  - the word-field positions (R_LSB=0, G_HI_LSB=10, FIELD_W);
  - the test-pattern rectangle constants.
- Sub-module vga_timing_gen: h/v counters plus hs/vs/active/frame-start decode. The top level adds arming, the read pipeline, unpack and underflow.

Test Plan:
- Reset, run 1 frame with FIFOs non-empty -> rd_req never 1; rd_load pulses once, 1 cycle after (h=0, v=480); hsync_n low for 96 cycles per line.
- Second frame, w1=16'h7FFF, w2=16'h0000 -> in active region vga_r=3FF, vga_g=3E0, vga_b=000; 307200 rd_req cycles counted.
- Check alignment with RD_LATENCY=1, w1 tracking the request index -> pixel_x=0, pixel_y=0 shows word #0; frame_start coincides; blank_n rises in the same cycle.
- Raise rd2_empty for one request at pixel (5,3) -> underflow=1 thereafter; pixel (5,3) black; neighbours intact.
- Assert reset mid-line at h=300, v=200 -> outputs return to reset values next cycle; rd_req stays 0 until after the next rd_load.
- With VGA_FRAME_READER_TESTPATTERN_EN and test_mode=1 -> pixel (110,150) = 3FF/01F/000; (0,0) = 000/01F/3FF; rd_req still toggles.
